uart_tx: RTL and testbench

//   8N1 UART transmitter. Directly downstream of the ASCII message sender: takes its one-cycle

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with integer-divided bit timing and one byte in flight.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   start    request strobe, accepted only while idle
//   tx_data  byte to send, latched with an accepted start
//   tx       serial line, idle high, LSB first
//   tx_busy  high while a frame is in progress
//   tx_done  one-cycle pulse when the stop bit completes
//
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit (11-bit frame). Without it the frame is 10 bits.
//
// All outputs are registered from the next-state values, so the start bit
// appears on the cycle right after the accepting edge. tx_busy drops at the
// same edge as tx_done, which allows a new start in the following cycle and
// leaves exactly one idle cycle between frames.
//
// state  | meaning
// IDLE   | line high, waiting for start; baud counter held at 0
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high)
module uart_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          tx_nxt, busy_nxt, done_nxt;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_nxt;
`endif

    assign bit_end = (cnt == LAST);

    // state register, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            idx     <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shift   <= shift_nxt;
            idx     <= idx_nxt;
            tx      <= tx_nxt;
            tx_busy <= busy_nxt;
            tx_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // next-state and datapath updates
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? '0 : cnt + CW'(1);
        shift_nxt = shift;
        idx_nxt   = idx;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    shift_nxt = tx_data;
                    idx_nxt   = 3'd0;
                    state_nxt = START;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output values for the state being entered
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == STOP) && bit_end;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (CLK_FREQ=1000, BAUD=100, 10 clocks per bit).
// A cycle-level reference model predicts tx/tx_busy/tx_done from frame start times;
// a line decoder recovers bytes from the recorded tx waveform.
module tb_uart_tx;

    localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FCYC = NBITS * BC;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int p     = 0;
    int n_busy;
    int n_done;

    // reference model: a frame accepted at edge m_p0 drives bit (p-m_p0)/BC
    logic m_active = 1'b0;
    int   m_p0     = 0;
    logic m_bits [0:NBITS-1];

    logic       txhist[$];
    logic [7:0] rx_q[$];
    logic       rx_par;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, p);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [7:0] d);
        logic e_tx, e_busy, e_done;
        reset   = r;
        start   = s;
        tx_data = d;
        @(posedge clk);
        p++;
        e_done = 1'b0;
        if (r) begin
            m_active = 1'b0;
        end else if (!m_active && s) begin
            m_active  = 1'b1;
            m_p0      = p;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9] = ^d;
`endif
            m_bits[NBITS-1] = 1'b1;
        end else if (m_active && (p - m_p0) == FCYC) begin
            m_active = 1'b0;
            e_done   = 1'b1;
        end
        e_busy = m_active;
        e_tx   = m_active ? m_bits[(p - m_p0) / BC] : 1'b1;
        #1;
        chk("tx", tx, e_tx);
        chk("tx_busy", tx_busy, e_busy);
        chk("tx_done", tx_done, e_done);
        txhist.push_back(tx);
        if (tx_busy === 1'b1) n_busy++;
        if (tx_done === 1'b1) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 400) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk({tag, " busy timeout"}, 32'(n < 400), 1);
    endtask

    task automatic clear();
        txhist.delete();
        n_busy = 0;
        n_done = 0;
    endtask

    task automatic decode(input string tag, input int want_gap);
        int i;
        int prev_end;
        logic [7:0] b;
        i        = 0;
        prev_end = -1;
        rx_q.delete();
        rx_par   = 1'bx;
        while (i < txhist.size()) begin
            if (txhist[i] == 1'b0) begin
                if (i + FCYC > txhist.size()) break;
                for (int k = 0; k < 8; k++) b[k] = txhist[i + (k + 1) * BC + BC / 2];
`ifdef UART_TX_PARITY_EN
                rx_par = txhist[i + 9 * BC + BC / 2];
`endif
                chk({tag, " stop bit"}, txhist[i + (NBITS - 1) * BC + BC / 2], 1);
                if (prev_end >= 0 && want_gap >= 0)
                    chk({tag, " gap"}, i - prev_end, want_gap);
                rx_q.push_back(b);
                prev_end = i + FCYC;
                i = prev_end;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c2[10] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
        logic [7:0] hello[5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        logic [7:0] d;
        int         k;

        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;

        // reset and idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        clear();
        idle(5);
        chk("idle busy count", n_busy, 0);

        // single frame 'h'
        clear();
        step(1'b0, 1'b1, 8'h68);
        wait_idle("t2");
        idle(3);
        for (int i = 0; i < 9; i++) chk("t2 bit centre", txhist[i * BC + BC / 2], c2[i]);
        chk("t2 stop centre", txhist[(NBITS - 1) * BC + BC / 2], c2[9]);
        chk("t2 busy cycles", n_busy, FCYC);
        chk("t2 done pulses", n_done, 1);

        // start during busy is ignored
        clear();
        step(1'b0, 1'b1, 8'h41);
        idle(3 * BC - 1);
        step(1'b0, 1'b1, 8'hFF);
        wait_idle("t3");
        idle(2 * FCYC);
        decode("t3", -1);
        chk("t3 frame count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t3 byte", rx_q[0], 8'h41);
        chk("t3 done pulses", n_done, 1);

        // back-to-back "hello" with busy handshake
        clear();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, hello[c]);
            wait_idle("t4");
        end
        idle(3);
        decode("t4", 1);
        chk("t4 frame count", rx_q.size(), 5);
        for (int c = 0; c < 5 && c < rx_q.size(); c++) chk("t4 byte", rx_q[c], hello[c]);
        chk("t4 done pulses", n_done, 5);

        // reset in data bit 4
        clear();
        step(1'b0, 1'b1, 8'h55);
        idle(5 * BC + 2);
        step(1'b1, 1'b0, 8'h00);
        chk("t5 tx after reset", tx, 1);
        chk("t5 busy after reset", tx_busy, 0);
        idle(3);
        chk("t5 done pulses", n_done, 0);
        step(1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        chk("t5 reset beats start", tx_busy, 0);
        clear();
        step(1'b0, 1'b1, 8'h0F);
        wait_idle("t5");
        idle(3);
        decode("t5", -1);
        chk("t5 frame count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t5 byte", rx_q[0], 8'h0F);
        chk("t5 done after restart", n_done, 1);

        // frame length and parity with 8'h07
        clear();
        step(1'b0, 1'b1, 8'h07);
        wait_idle("t6");
        idle(3);
        decode("t6", -1);
        if (rx_q.size() > 0) chk("t6 byte", rx_q[0], 8'h07);
`ifdef UART_TX_PARITY_EN
        chk("t6 busy cycles", n_busy, 110);
        chk("t6 parity bit", rx_par, 1);
`else
        chk("t6 busy cycles", n_busy, 100);
`endif

        // randomized traffic: extra starts, random gaps, occasional resets
        for (int it = 0; it < 40; it++) begin
            d = 8'($urandom);
            step(1'b0, 1'b1, d);
            k = $urandom_range(0, FCYC + 15);
            for (int j = 0; j < k; j++) begin
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0), 8'($urandom));
            end
        end
        step(1'b0, 1'b0, 8'h00);
        wait_idle("rand");
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
